// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and alignment helpers shared by the memory access unit.
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // Offset bits that must be zero for an access of this size; 2'b11 behaves as a word.
    function automatic logic [1:0] size_mask(input logic [1:0] size);
        return (size == SZ_WORD || size == 2'b11) ? 2'b11 : {1'b0, size == SZ_HALF};
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return |(off & size_mask(size));
    endfunction
endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: little-endian lane extract with sign/zero extension for loads, lane merge for stores.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size_i,
    input  logic [1:0]            off_i,
    input  logic                  uns_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic [DATA_WIDTH-1:0] st_data_o
);
    logic [4:0]            bsh;
    logic [4:0]            hsh;
    logic [7:0]            lb;
    logic [15:0]           lh;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] lane_data;
    logic                  sub_word;

    assign bsh = {off_i, 3'b000};
    assign hsh = {off_i[1], 4'b0000};
    assign lb  = rdata_i[bsh +: 8];
    assign lh  = rdata_i[hsh +: 16];
    assign sub_word = (size_i == SZ_BYTE) || (size_i == SZ_HALF);

    assign ld_data_o = (size_i == SZ_BYTE) ? {{(DATA_WIDTH-8){~uns_i & lb[7]}}, lb} :
                       (size_i == SZ_HALF) ? {{(DATA_WIDTH-16){~uns_i & lh[15]}}, lh} : rdata_i;

    assign lane_mask = (size_i == SZ_BYTE) ? DATA_WIDTH'(8'hFF) << bsh : DATA_WIDTH'(16'hFFFF) << hsh;
    assign lane_data = (size_i == SZ_BYTE) ? wdata_i << bsh : wdata_i << hsh;
    assign st_data_o = sub_word ? (rdata_i & ~lane_mask) | (lane_data & lane_mask) : wdata_i;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator doing read-modify-write sub-word stores on a word-only memory.
// MEM_ACCESS_MISALIGN_TRAP_EN: misaligned requests skip memory and respond with resp_err=1.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_uns,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_rd,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    state_t                state_q;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_rd_q;
    logic                  valid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_data;
    logic [1:0]            req_off;
    logic                  req_mis;
    logic                  unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign req_mis = misaligned(req_size, req_addr[1:0]);
    assign req_off = req_addr[1:0];
`else
    assign req_mis = 1'b0;
    assign req_off = req_addr[1:0] & ~size_mask(req_size);
`endif

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i   (size_q),
        .off_i    (off_q),
        .uns_i    (uns_q),
        .rdata_i  (mem_rdata),
        .wdata_i  (wdata_q),
        .ld_data_o(ld_data),
        .st_data_o(st_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            wdata_q <= '0;
            addr_q  <= '0;
            wr_rd_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    uns_q   <= req_uns;
                    size_q  <= req_size;
                    off_q   <= req_off;
                    wdata_q <= req_wdata;
                    err_q   <= req_mis;
                    rdata_q <= '0;
                    if (req_mis) begin
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        addr_q  <= req_addr[ADDR_WIDTH+1:2];
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    wr_rd_q <= ~we_q;
                    state_q <= DATA;
                end
                DATA: begin
                    wr_rd_q <= 1'b1;
                    rdata_q <= we_q ? '0 : ld_data;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (resp_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data is only meaningful while the write strobe is low, which is DATA of a store.
    assign mem_wdata  = wr_rd_q ? '0 : st_data;
    assign mem_addr   = addr_q;
    assign mem_wr_rd  = wr_rd_q;
    assign req_ready  = (state_q == IDLE) & ~rst;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural single-port word memory.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic        mem_wr_rd;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wr_rd(mem_wr_rd), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:1023];
    logic [9:0]  samp = '0;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    int          wr_cnt = 0;
    logic [9:0]  wr_addr = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (!mem_wr_rd) begin
            mem[samp] <= mem_wdata;
            wr_cnt    <= wr_cnt + 1;
            wr_addr   <= samp;
        end
        samp <= mem_addr;
    end
    assign mem_rdata = mem[samp];

    typedef struct {logic [31:0] data; logic err;} exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] ls_addr [5] = '{32'h7, 32'h7, 32'h6, 32'h4, 32'h5};
    logic [1:0]  ls_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        ls_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ls_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234, 32'h00000012};

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] rd, output logic err,
                        output int lat, output logic stable, output logic idle);
        int w = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        rd = resp_rdata; err = resp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = '0; req_wdata = 32'hDEADBEEF;
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd || resp_err !== err || req_ready) stable = 1'b0;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        idle = req_ready && !resp_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 7;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
        if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
        if (mem_addr !== 10'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        if (mem_wr_rd !== 1'b1) begin n_fail++; $display("FAIL rst_mem_wr_rd got %b exp 1", mem_wr_rd); end
        if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_load_word();
        logic [31:0] rd; logic err, st, idl; int lat, wc; exp_t e;
        preload(10'd0, 32'h000007D1);
        wc = wr_cnt;
        exp_q.push_back('{data: 32'h000007D1, err: 1'b0});
        xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks += 5;
        if (rd !== e.data) begin n_fail++; $display("FAIL lw_rdata got %h exp %h", rd, e.data); end
        if (err !== e.err) begin n_fail++; $display("FAIL lw_err got %b exp %b", err, e.err); end
        if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
        if (wr_cnt !== wc) begin n_fail++; $display("FAIL lw_no_write got %0d exp %0d", wr_cnt, wc); end
        if (idl !== 1'b1) begin n_fail++; $display("FAIL lw_idle got %b exp 1", idl); end
    endtask

    task automatic test_load_sub();
        logic [31:0] rd; logic err, st, idl; int lat; exp_t e;
        preload(10'd1, 32'h80FF1234);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{data: ls_exp[i], err: 1'b0});
            xact(1'b0, ls_size[i], ls_uns[i], ls_addr[i], 32'h0, 0, rd, err, lat, st, idl);
            e = exp_q.pop_front();
            n_checks += 2;
            if (rd !== e.data) begin n_fail++; $display("FAIL ld_sub[%0d] rdata got %h exp %h", i, rd, e.data); end
            if (err !== e.err) begin n_fail++; $display("FAIL ld_sub[%0d] err got %b exp %b", i, err, e.err); end
        end
    endtask

    task automatic test_store_sub();
        logic [31:0] rd; logic err, st, idl; int lat, wc; exp_t e;
        preload(10'd1, 32'h11223344);
        wc = wr_cnt;
        exp_q.push_back('{data: 32'h0, err: 1'b0});
        xact(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAB, 0, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks += 5;
        if (rd !== e.data) begin n_fail++; $display("FAIL sb_rdata got %h exp %h", rd, e.data); end
        if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d exp 3", lat); end
        if (wr_cnt !== wc + 1) begin n_fail++; $display("FAIL sb_write_count got %0d exp %0d", wr_cnt, wc + 1); end
        if (wr_addr !== 10'd1) begin n_fail++; $display("FAIL sb_write_addr got %0d exp 1", wr_addr); end
        if (mem[1] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_word1 got %h exp 1122ab44", mem[1]); end
        xact(1'b1, 2'b01, 1'b0, 32'h4, 32'h5A5ABEEF, 0, rd, err, lat, st, idl);
        n_checks += 2;
        if (mem[1] !== 32'h1122BEEF) begin n_fail++; $display("FAIL sh_word1 got %h exp 1122beef", mem[1]); end
        if (wr_cnt !== wc + 2) begin n_fail++; $display("FAIL sh_write_count got %0d exp %0d", wr_cnt, wc + 2); end
        xact(1'b1, 2'b11, 1'b0, 32'hC, 32'hA5A50F0F, 0, rd, err, lat, st, idl);
        n_checks++;
        if (mem[3] !== 32'hA5A50F0F) begin n_fail++; $display("FAIL sw_word3 got %h exp a5a50f0f", mem[3]); end
        exp_q.push_back('{data: 32'h1122BEEF, err: 1'b0});
        xact(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e.data) begin n_fail++; $display("FAIL lw_wrap got %h exp %h", rd, e.data); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic err, st, idl; int lat, wc, xlat; logic [31:0] xw1; exp_t e;
        wc = wr_cnt;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        exp_q.push_back('{data: 32'h0, err: 1'b1});
        xlat = 1;
        xw1 = 32'h1122BEEF;
`else
        exp_q.push_back('{data: 32'h000007D1, err: 1'b0});
        xlat = 3;
        xw1 = 32'h5555BEEF;
`endif
        xact(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks += 4;
        if (rd !== e.data) begin n_fail++; $display("FAIL mis_lw_rdata got %h exp %h", rd, e.data); end
        if (err !== e.err) begin n_fail++; $display("FAIL mis_lw_err got %b exp %b", err, e.err); end
        if (lat !== xlat) begin n_fail++; $display("FAIL mis_lw_latency got %0d exp %0d", lat, xlat); end
        if (wr_cnt !== wc) begin n_fail++; $display("FAIL mis_lw_no_write got %0d exp %0d", wr_cnt, wc); end
        xact(1'b1, 2'b01, 1'b0, 32'h7, 32'h00005555, 0, rd, err, lat, st, idl);
        n_checks += 2;
        if (mem[1] !== xw1) begin n_fail++; $display("FAIL mis_sh_word1 got %h exp %h", mem[1], xw1); end
        if (err !== e.err) begin n_fail++; $display("FAIL mis_sh_err got %b exp %b", err, e.err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err, st, idl; int lat, wc; exp_t e;
        wc = wr_cnt;
        exp_q.push_back('{data: 32'h000007D1, err: 1'b0});
        xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks += 5;
        if (rd !== e.data) begin n_fail++; $display("FAIL bp_rdata got %h exp %h", rd, e.data); end
        if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b exp 1", st); end
        if (idl !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after_release got %b exp 1", idl); end
        if (wr_cnt !== wc) begin n_fail++; $display("FAIL bp_no_accept got %0d writes exp %0d", wr_cnt, wc); end
        if (mem[0] !== 32'h000007D1) begin n_fail++; $display("FAIL bp_word0 got %h exp 000007d1", mem[0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, st, idl; int lat, wc; exp_t e;
        preload(10'd2, 32'hCAFEF00D);
        wc = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_wr_rd !== 1'b0) begin n_fail++; $display("FAIL rm_in_data_wr_rd got %b exp 0", mem_wr_rd); end
        #1 rst = 1'b1;
        #1;
        n_checks += 3;
        if (mem_wr_rd !== 1'b1) begin n_fail++; $display("FAIL rm_async_wr_rd got %b exp 1", mem_wr_rd); end
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_resp_valid got %b exp 0", resp_valid); end
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_rst got %b exp 0", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks += 3;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after got %b exp 1", req_ready); end
        if (mem[2] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rm_word2 got %h exp cafef00d", mem[2]); end
        if (wr_cnt !== wc) begin n_fail++; $display("FAIL rm_no_write got %0d exp %0d", wr_cnt, wc); end
        exp_q.push_back('{data: 32'hCAFEF00D, err: 1'b0});
        xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, rd, err, lat, st, idl);
        e = exp_q.pop_front();
        n_checks++;
        if (rd !== e.data) begin n_fail++; $display("FAIL rm_reload got %h exp %h", rd, e.data); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store_sub();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
